// File: rtl/serial_comparator.sv
// Multi-cycle W-bit magnitude comparator: D-bit ripple subtract per cycle.
// Define SIGNED_CMP_EN for a two's-complement compare.
module serial_comparator #(
  parameter int W = 8,
  parameter int D = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [1:0]   r,
  output logic         zr,
  output logic         brw
);

  localparam int S  = W / D;
  localparam int CW = (S > 1) ? $clog2(S) : 1;
  localparam logic [CW-1:0] LAST = CW'(S - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t        state_q;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic [CW-1:0] cnt_q;
  logic          bor_q;
  logic          nz_q;
  logic          anz_q;
  logic          busy_q;
  logic          done_q;
  logic [1:0]    r_q;
  logic          zr_q;
  logic          brw_q;

  logic [W-1:0]  a_cap;
  logic [W-1:0]  b_cap;
  logic [D:0]    sl_d;
  logic          bor_d;
  logic          nz_d;
  logic [1:0]    r_d;

  // Flipping the MSBs maps two's-complement order onto unsigned order.
  always_comb begin
    a_cap = a;
    b_cap = b;
`ifdef SIGNED_CMP_EN
    a_cap[W-1] = ~a[W-1];
    b_cap[W-1] = ~b[W-1];
`else
    a_cap[W-1] = a[W-1];
    b_cap[W-1] = b[W-1];
`endif
  end

  assign sl_d  = {1'b0, a_q[D-1:0]}
               - {1'b0, b_q[D-1:0]}
               - {{D{1'b0}}, bor_q};
  assign bor_d = sl_d[D];
  assign nz_d  = nz_q | (|sl_d[D-1:0]);

  always_comb begin
    r_d = 2'b00;
    unique case (1'b1)
      (!nz_q &&  anz_q): r_d = 2'b00;
      (!nz_q && !anz_q): r_d = 2'b11;
      ( nz_q && !bor_q): r_d = 2'b01;
      ( nz_q &&  bor_q): r_d = 2'b10;
      default:           r_d = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      bor_q   <= 1'b0;
      nz_q    <= 1'b0;
      anz_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      r_q     <= 2'b00;
      zr_q    <= 1'b0;
      brw_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= a_cap;
            b_q     <= b_cap;
            cnt_q   <= '0;
            bor_q   <= 1'b0;
            nz_q    <= 1'b0;
            anz_q   <= |a;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          bor_q <= bor_d;
          nz_q  <= nz_d;
          a_q   <= a_q >> D;
          b_q   <= b_q >> D;
          if (cnt_q == LAST) begin
            cnt_q   <= '0;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          r_q     <= r_d;
          zr_q    <= nz_q;
          brw_q   <= bor_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign r    = r_q;
  assign zr   = zr_q;
  assign brw  = brw_q;

endmodule

// File: tb/tb_serial_comparator.sv
// Directed bench for serial_comparator (W=8, D=2).
// Expectations switch with SIGNED_CMP_EN where the relation differs.
module tb_serial_comparator;

  localparam int W   = 8;
  localparam int D   = 2;
  localparam int LAT = W / D + 1;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [1:0]   r;
  logic         zr;
  logic         brw;

  int n_cmp;
  int n_bad;

  serial_comparator #(.W(W), .D(D)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .a    (a),
    .b    (b),
    .busy (busy),
    .done (done),
    .r    (r),
    .zr   (zr),
    .brw  (brw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Launch one compare; lat = edges from acceptance to done (0 = timeout).
  task automatic run_cmp(input logic [W-1:0] av,
                         input logic [W-1:0] bv,
                         output int lat,
                         output logic bsy);
    lat = 0;
    @(negedge clk);
    a = av;
    b = bv;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    bsy = busy;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    n_cmp++;
    if ({busy, done, r, zr, brw} !== 6'b0) begin
      n_bad++;
      $display("FAIL reset_state got=%b want=000000",
               {busy, done, r, zr, brw});
    end
  endtask

  task automatic test_equal;
    int lat;
    logic bsy;
    run_cmp(8'h5A, 8'h5A, lat, bsy);
    n_cmp++;
    if (bsy !== 1'b1) begin
      n_bad++;
      $display("FAIL equal_busy got=%b want=1", bsy);
    end
    n_cmp++;
    if (lat != LAT) begin
      n_bad++;
      $display("FAIL equal_latency got=%0d want=%0d", lat, LAT);
    end
    n_cmp++;
    if ({r, zr, brw, busy} !== 5'b00000) begin
      n_bad++;
      $display("FAIL equal_result got=%b want=00000",
               {r, zr, brw, busy});
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (done !== 1'b0 || r !== 2'b00) begin
      n_bad++;
      $display("FAIL equal_pulse done=%b r=%b want done=0 r=00",
               done, r);
    end
  endtask

  task automatic test_zero;
    int lat;
    logic bsy;
    run_cmp(8'h00, 8'h00, lat, bsy);
    n_cmp++;
    if (lat != LAT || {r, zr, brw} !== 4'b1100) begin
      n_bad++;
      $display("FAIL zero_zero lat=%0d res=%b want lat=%0d res=1100",
               lat, {r, zr, brw}, LAT);
    end
    run_cmp(8'h01, 8'h00, lat, bsy);
    n_cmp++;
    if (lat != LAT || {r, zr, brw} !== 4'b0110) begin
      n_bad++;
      $display("FAIL one_zero lat=%0d res=%b want lat=%0d res=0110",
               lat, {r, zr, brw}, LAT);
    end
  endtask

  task automatic test_borrow;
    int lat;
    logic bsy;
    run_cmp(8'h00, 8'h01, lat, bsy);
    n_cmp++;
    if (lat != LAT || {r, zr, brw} !== 4'b1011) begin
      n_bad++;
      $display("FAIL borrow_chain lat=%0d res=%b want lat=%0d res=1011",
               lat, {r, zr, brw}, LAT);
    end
    run_cmp(8'hFF, 8'h80, lat, bsy);
    n_cmp++;
    if (lat != LAT || {r, zr, brw} !== 4'b0110) begin
      n_bad++;
      $display("FAIL ff_80 lat=%0d res=%b want lat=%0d res=0110",
               lat, {r, zr, brw}, LAT);
    end
  endtask

  task automatic test_signed;
    int lat;
    logic bsy;
    logic [1:0] want;
`ifdef SIGNED_CMP_EN
    want = 2'b10;
`else
    want = 2'b01;
`endif
    run_cmp(8'hFF, 8'h01, lat, bsy);
    n_cmp++;
    if (lat != LAT || r !== want || zr !== 1'b1) begin
      n_bad++;
      $display("FAIL sgn_ff_01 lat=%0d r=%b zr=%b want r=%b zr=1",
               lat, r, zr, want);
    end
    run_cmp(8'h80, 8'h7F, lat, bsy);
    n_cmp++;
    if (lat != LAT || r !== want || zr !== 1'b1) begin
      n_bad++;
      $display("FAIL sgn_80_7f lat=%0d r=%b zr=%b want r=%b zr=1",
               lat, r, zr, want);
    end
  endtask

  task automatic test_back_to_back;
    int npulse;
    int t0;
    int t1;
    logic rbad;
    npulse = 0;
    t0 = -1;
    t1 = -1;
    rbad = 1'b0;
    @(negedge clk);
    a = 8'd3;
    b = 8'd9;
    start = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (i == 9) start = 1'b0;
      if (done) begin
        npulse++;
        if (t0 < 0) t0 = i;
        else t1 = i;
        if (r !== 2'b10) rbad = 1'b1;
      end
    end
    n_cmp++;
    if (npulse != 2) begin
      n_bad++;
      $display("FAIL b2b_count got=%0d want=2", npulse);
    end
    n_cmp++;
    if (t1 - t0 != LAT + 1) begin
      n_bad++;
      $display("FAIL b2b_gap got=%0d want=%0d", t1 - t0, LAT + 1);
    end
    n_cmp++;
    if (rbad !== 1'b0 || t0 != LAT) begin
      n_bad++;
      $display("FAIL b2b_result rbad=%b first=%0d want rbad=0 first=%0d",
               rbad, t0, LAT);
    end
  endtask

  task automatic test_busy_ignore;
    int lat;
    int extra;
    lat = 0;
    extra = 0;
    @(negedge clk);
    a = 8'd3;
    b = 8'd9;
    start = 1'b1;
    @(negedge clk);
    a = 8'd9;
    b = 8'd3;
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = 8'd0;
    b = 8'd0;
    for (int i = 3; i <= 30; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        if (lat == 0) lat = i;
        else extra++;
      end
    end
    n_cmp++;
    if (lat != LAT || r !== 2'b10 || extra != 0) begin
      n_bad++;
      $display("FAIL busy_ignore lat=%0d r=%b extra=%0d want %0d/10/0",
               lat, r, extra, LAT);
    end
  endtask

  task automatic test_reset_mid_run;
    int ndone;
    ndone = 0;
    @(negedge clk);
    a = 8'h00;
    b = 8'h01;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, done, r, zr, brw} !== 6'b0) begin
      n_bad++;
      $display("FAIL reset_mid_run got=%b want=000000",
               {busy, done, r, zr, brw});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) ndone++;
    end
    n_cmp++;
    if (ndone != 0) begin
      n_bad++;
      $display("FAIL reset_no_done got=%0d want=0", ndone);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    #12;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    test_equal();
    test_zero();
    test_borrow();
    test_signed();
    test_back_to_back();
    test_busy_ignore();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
